// File: rtl/alu_pkg.sv
// Shared opcodes, issue-stage FSM states and the divide-by-zero predicate.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_MUL  = 4'b0010;
  localparam logic [3:0] ALU_DIV  = 4'b0011;
  localparam logic [3:0] ALU_MOD  = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1000;
  localparam logic [3:0] ALU_NAND = 4'b1001;
  localparam logic [3:0] ALU_XNOR = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1011;
  localparam logic [3:0] ALU_SLTU = 4'b1100;
  localparam logic [3:0] ALU_SHL  = 4'b1101;
  localparam logic [3:0] ALU_SHR  = 4'b1110;
  localparam logic [3:0] ALU_ASR  = 4'b1111;

  // Widest operand the zero check supports; callers zero-extend into it.
  localparam int unsigned DIV_CHK_W = 64;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_FIRE  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // True when the command would divide or take a modulo by zero.
  function automatic logic is_div_zero(input logic [3:0] op, input logic [DIV_CHK_W-1:0] b);
    return ((op == ALU_DIV) || (op == ALU_MOD)) && (b == '0);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; head is visible combinationally, no write-through bypass.
module cmd_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap because DEPTH is a power of two.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Control registers with synchronous flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care once flushed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage in front of the combinational ALU: queue, opcode-toggle issue, response hold.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAGW  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_ctrl,
  input  logic [W-1:0]        in_a,
  input  logic [W-1:0]        in_b,
  input  logic [W-1:0]        in_c,
  input  logic [TAGW-1:0]     in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_d,
  output logic [TAGW-1:0]     out_tag,
  output logic                out_err,
  output logic [3:0]          alu_ctrl,
  output logic [W-1:0]        alu_a,
  output logic [W-1:0]        alu_b,
  output logic [W-1:0]        alu_c,
  input  logic signed [W-1:0] alu_d,
  output logic                busy
);

  localparam int unsigned PW = 4 + 3 * W + TAGW;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [PW-1:0]   fifo_rdata;
  logic            fifo_full, fifo_empty, fifo_pop;
  logic [CW-1:0]   fifo_count;
  logic [3:0]      h_op;
  logic [W-1:0]    h_a, h_b, h_c;
  logic [TAGW-1:0] h_tag;
  logic            issue;

  state_e                state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic signed [W-1:0]   out_d_q, out_d_d;
  logic [TAGW-1:0]       out_tag_q, out_tag_d;
  logic                  out_err_q, out_err_d;
  logic [3:0]            alu_ctrl_q, alu_ctrl_d;
  logic [W-1:0]          alu_a_q, alu_a_d, alu_b_q, alu_b_d, alu_c_q, alu_c_d;
  logic [3:0]            op_q, op_d;
  logic [TAGW-1:0]       tag_q, tag_d;

  cmd_fifo #(.DW(PW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (fifo_pop),
    .wdata ({in_ctrl, in_a, in_b, in_c, in_tag}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign {h_op, h_a, h_b, h_c, h_tag} = fifo_rdata;

  assign in_ready  = !fifo_full;
  assign busy      = (state_q != S_IDLE) || (fifo_count != '0);
  assign out_valid = out_valid_q;
  assign out_d     = out_d_q;
  assign out_tag   = out_tag_q;
  assign out_err   = out_err_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_c     = alu_c_q;

  // Next-state and output decode; a pop from IDLE or a completed RESP share one issue path.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_d_d     = out_d_q;
    out_tag_d   = out_tag_q;
    out_err_d   = out_err_q;
    alu_ctrl_d  = alu_ctrl_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_c_d     = alu_c_q;
    op_d        = op_q;
    tag_d       = tag_q;
    fifo_pop    = 1'b0;
    issue       = !fifo_empty &&
                  ((state_q == S_IDLE) || ((state_q == S_RESP) && out_ready));

    case (state_q)
      S_SETUP: begin
        alu_ctrl_d = op_q;
        state_d    = S_FIRE;
      end
      S_FIRE: begin
        out_valid_d = 1'b1;
        out_d_d     = alu_d;
        out_tag_d   = tag_q;
        out_err_d   = 1'b0;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: ;
    endcase

    if (issue) begin
      fifo_pop = 1'b1;
      if (is_div_zero(h_op, DIV_CHK_W'(h_b))) begin
        out_valid_d = 1'b1;
        out_d_d     = '0;
        out_err_d   = 1'b1;
        out_tag_d   = h_tag;
        state_d     = S_RESP;
      end else begin
        alu_a_d    = h_a;
        alu_b_d    = h_b;
        alu_c_d    = h_c;
        alu_ctrl_d = ~h_op;
        op_d       = h_op;
        tag_d      = h_tag;
        state_d    = S_SETUP;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_d_q     <= '0;
      out_tag_q   <= '0;
      out_err_q   <= 1'b0;
      alu_ctrl_q  <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_c_q     <= '0;
      op_q        <= '0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_d_q     <= out_d_d;
      out_tag_q   <= out_tag_d;
      out_err_q   <= out_err_d;
      alu_ctrl_q  <= alu_ctrl_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_c_q     <= alu_c_d;
      op_q        <= op_d;
      tag_q       <= tag_d;
    end
  end

endmodule
